// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential multiplier/scaler.
// Holds the FSM state type, a counter-width helper and an elaboration guard.
`ifndef SEQ_MULT_PKG_SV
`define SEQ_MULT_PKG_SV

// Stops elaboration when NUM is not a multiple of DEN.
`define SEQ_MULT_CHECK_DIV(NUM, DEN, MSG) \
  if (((NUM) % (DEN)) != 0) begin : g_div_check \
    $error(MSG); \
  end

package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

`endif

// File: rtl/mult_pp_step.sv
// One radix-2^BPC step: adds mcand * digit, shifted left by shamt, to the accumulator.
// Purely combinational; the digit width is the only thing that changes with radix.
module mult_pp_step #(
  parameter int A_W   = 8,
  parameter int BPC   = 1,
  parameter int ACC_W = 17,
  parameter int SH_W  = 4
) (
  input  logic [A_W-1:0]   mcand,
  input  logic [BPC-1:0]   digit,
  input  logic [SH_W-1:0]  shamt,
  input  logic [ACC_W-1:0] acc_in,
  output logic [ACC_W-1:0] acc_out
);

  logic [ACC_W-1:0] term [BPC];
  logic [ACC_W-1:0] pp;

  // One shifted copy of mcand per digit bit; their sum is mcand * digit.
  for (genvar gi = 0; gi < BPC; gi++) begin : g_term
    assign term[gi] = digit[gi] ? (ACC_W'(mcand) << gi) : '0;
  end

  always_comb begin
    pp = '0;
    for (int i = 0; i < BPC; i++) begin
      pp = pp + term[i];
    end
  end

  assign acc_out = acc_in + (pp << shamt);

endmodule

// File: rtl/seq_mult_scaler.sv
// Sequential unsigned multiplier with valid/ready on both sides and an optional
// round-half-up right shift of the product.
module seq_mult_scaler
  import seq_mult_pkg::*;
#(
  parameter int A_W       = 8,
  parameter int B_W       = 8,
  parameter int BPC       = 1,
  parameter int OUT_SHIFT = 0,
  localparam int OUT_W    = A_W + B_W - OUT_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             busy
);

  localparam int N     = B_W / BPC;
  localparam int ACC_W = A_W + B_W + 1;
  localparam int CNT_W = clog2(N + 1);
  localparam int SH_W  = clog2(B_W + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [SH_W-1:0]  SH_STEP  = SH_W'(BPC);
  // Half an output LSB; zero when no shift is applied.
  localparam logic [ACC_W-1:0] RND_ADD  = (ACC_W'(1) << OUT_SHIFT) >> 1;

  `SEQ_MULT_CHECK_DIV(B_W, BPC, "seq_mult_scaler: BPC must divide B_W")

  if (OUT_SHIFT < 0 || OUT_SHIFT > A_W + B_W - 1) begin : g_shift_check
    $error("seq_mult_scaler: OUT_SHIFT out of range");
  end

  state_e           state_q, state_d;
  logic [A_W-1:0]   mcand_q, mcand_d;
  logic [B_W-1:0]   mplier_q, mplier_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SH_W-1:0]  shamt_q, shamt_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic [ACC_W-1:0] acc_next;

  mult_pp_step #(
    .A_W   (A_W),
    .BPC   (BPC),
    .ACC_W (ACC_W),
    .SH_W  (SH_W)
  ) u_pp_step (
    .mcand   (mcand_q),
    .digit   (mplier_q[BPC-1:0]),
    .shamt   (shamt_q),
    .acc_in  (acc_q),
    .acc_out (acc_next)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    shamt_d  = shamt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = CNT_LOAD;
          shamt_d  = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> BPC;
        cnt_d    = cnt_q - CNT_W'(1);
        shamt_d  = shamt_q + SH_STEP;
        // Last digit: the rounded product is captured from the final sum directly.
        if (cnt_q == CNT_W'(1)) begin
          result_d = OUT_W'((acc_next + RND_ADD) >> OUT_SHIFT);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      shamt_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule

// File: doc/seq_mult_scaler.md
Name: seq_mult_scaler

Overview:
Parametrised sequential unsigned multiplier for the colour/brightness datapath. It succeeds the fixed 8x8 load/ready multiplier. Operand widths are configurable, and the radix (multiplier bits retired per cycle) is configurable. It adds a valid/ready handshake on both sides and an optional rounded right-shift of the product. Typical use is scaling an 8-bit channel value by an 8-bit brightness ahead of the PWM generators.

Parameters:
A_W, 8, multiplicand width (bits, >=2)
B_W, 8, multiplier width (bits, >=2)
BPC, 1, multiplier bits retired per cycle; must divide B_W (elaboration error otherwise)
OUT_SHIFT, 0, right shift applied to product with round-half-up; 0..A_W+B_W-1
OUT_W, A_W+B_W-OUT_SHIFT, result width (derived, not overridable)

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  operands a/b valid
in_ready  out  1  block can accept operands
a  in  A_W  multiplicand, unsigned
b  in  B_W  multiplier, unsigned
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  OUT_W  rounded, shifted product
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (clk edge with reset=0): state=IDLE, accumulator=0, result=0, out_valid=0. in_ready reads 1 one cycle after reset is released; busy=0. Reset wins over everything, including mid-RUN; an in-flight operation is discarded and produces no out_valid.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE); combinational decode of registered state only.
- out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE: on edge with in_valid&in_ready, latch a into mcand and b into mplier shift register, clear accumulator, load step counter N=B_W/BPC, go to RUN. Otherwise stay.
- RUN, each edge:
  - accumulator += (mcand * mplier[BPC-1:0]) << (BPC*step_index).
  - mplier shifts right by BPC; counter decrements.
  - On the edge where counter reaches 0, register result and go to DONE.
  - result = (acc_final + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0)) >> OUT_SHIFT.
  - Accumulator width is A_W+B_W+1, so rounding cannot overflow. Result always fits OUT_W; no saturation logic.
- Latency: accept edge E0; out_valid first high after edge E0+N. N=8 for default params, 4 for BPC=2.
- DONE: result and out_valid held stable while out_ready=0, indefinitely.
  - Edge with out_ready=1: go to IDLE, out_valid drops; result keeps its last value.
  - New operands can be accepted no earlier than the following edge. Back-to-back throughput is one product per N+2 cycles.
- in_valid while busy: ignored, no latching; a/b may change freely.
- in_valid and out_ready asserted together in DONE: only the output transfer happens.
- a=0 or b=0: full N cycles still run (deterministic latency); result=0.
- Rounding: ties round up (e.g. product 0x0080, OUT_SHIFT=8 -> 1).

Decomposition:
- Shared package seq_mult_pkg:
  - state enum (IDLE, RUN, DONE)
  - clog2 function for counter width
  - elaboration check macro for B_W % BPC
- One sub-module is natural: mult_pp_step, a combinational partial-product adder. It takes mcand, a BPC-bit digit, a shift amount and the accumulator, and returns the next accumulator. It is reused unchanged for any BPC.

Test Plan:
- Default params, a=255, b=255, out_ready=1 -> in_ready low for 9 cycles after accept; out_valid high one cycle on edge E0+8; result=65025 (0xFE01).
- OUT_SHIFT=8, a=200, b=128 -> result=100 (25600+128=25728>>8). Also a=1, b=128 -> result=1 (exact tie rounds up).
- Backpressure: out_ready=0 for 20 cycles after out_valid -> result/out_valid stable, in_ready=0, a new in_valid pulse is ignored; out_ready=1 -> IDLE next edge, next accept completes with the correct product.
- Reset mid-RUN: reset=0 on the 3rd RUN cycle -> next cycle out_valid=0, result=0, in_ready=1; subsequent 13*11 yields 143.
- BPC=2, A_W=B_W=8: a=171, b=205 -> out_valid on edge E0+4, result=35055. Back-to-back streaming of 100 random pairs with random out_ready matches the reference model.
- Zero operand: a=0, b=77 -> result=0 with full latency N; no early out_valid.
